// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the FSM state encoding and a one-hot to index helper.
package mem_arb_pkg;

  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 8;
  localparam int N_REQ_MAX = 8;
  localparam int IDX_W     = $clog2(N_REQ_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [N_REQ_MAX-1:0] oh
  );
    oh2idx = '0;
    for (int i = 0; i < N_REQ_MAX; i++)
      if (oh[i]) oh2idx = IDX_W'(i);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-interface signal bundle for mem_port_arbiter.
// master = arbiter side, slave = requesters plus memory interface.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
);

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    req_done;
  logic [DW-1:0]       rd_data;
  logic [AW-1:0]       mi_addr;
  logic [DW-1:0]       mi_wr_data;
  logic                mi_wr_start;
  logic                mi_rd_start;
  logic                mi_wr_done;
  logic                mi_rd_done;
  logic [DW-1:0]       mi_rd_data;

  modport master (
    input  req, req_we, req_addr, req_wdata,
    input  mi_wr_done, mi_rd_done, mi_rd_data,
    output gnt, req_done, rd_data,
    output mi_addr, mi_wr_data,
    output mi_wr_start, mi_rd_start
  );

  modport slave (
    output req, req_we, req_addr, req_wdata,
    output mi_wr_done, mi_rd_done, mi_rd_data,
    input  gnt, req_done, rd_data,
    input  mi_addr, mi_wr_data,
    input  mi_wr_start, mi_rd_start
  );

endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// One-hot winner select: first set req bit at or after ptr.
// With ptr held at 0 this degenerates to lowest-index priority.
module rr_picker #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick
);

  logic found;
  int   idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory access path among N_REQ requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin, else fixed priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input logic               clk,
  input logic               nreset,
  mem_port_arbiter_if.master bus
);

  localparam int PW = $clog2(N_REQ);

  arb_state_t       state, state_d;
  logic [N_REQ-1:0] pick, gnt_d, done_d;
  logic             we, we_d;
  logic             wr_st_d, rd_st_d;
  logic [AW-1:0]    addr_d;
  logic [DW-1:0]    wdata_d, rdat_d;
  logic [PW-1:0]    ptr;
  logic             mem_done;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PW-1:0]    ptr_d;
  logic [IDX_W-1:0] win_idx;
`else
  assign ptr = '0;
`endif

  rr_picker #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick)
  );

  // Only the done matching the latched access kind counts.
  assign mem_done = we ? bus.mi_wr_done
                       : bus.mi_rd_done;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state           <= IDLE;
      we              <= 1'b0;
      bus.gnt         <= '0;
      bus.req_done    <= '0;
      bus.mi_wr_start <= 1'b0;
      bus.mi_rd_start <= 1'b0;
      bus.mi_addr     <= '0;
      bus.mi_wr_data  <= '0;
      bus.rd_data     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr             <= '0;
`endif
    end else begin
      state           <= state_d;
      we              <= we_d;
      bus.gnt         <= gnt_d;
      bus.req_done    <= done_d;
      bus.mi_wr_start <= wr_st_d;
      bus.mi_rd_start <= rd_st_d;
      bus.mi_addr     <= addr_d;
      bus.mi_wr_data  <= wdata_d;
      bus.rd_data     <= rdat_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr             <= ptr_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (|bus.req) state_d = ISSUE;
      ISSUE: state_d = WAIT;
      WAIT:  if (mem_done) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gnt_d   = bus.gnt;
    done_d  = '0;
    we_d    = we;
    wr_st_d = 1'b0;
    rd_st_d = 1'b0;
    addr_d  = bus.mi_addr;
    wdata_d = bus.mi_wr_data;
    rdat_d  = bus.rd_data;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    ptr_d   = ptr;
    win_idx = oh2idx(N_REQ_MAX'(pick));
`endif
    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          gnt_d = pick;
          we_d  = |(pick & bus.req_we);
          for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
              addr_d  = bus.req_addr[i*AW +: AW];
              wdata_d = bus.req_wdata[i*DW +: DW];
            end
          end
          wr_st_d = we_d;
          rd_st_d = !we_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          if (int'(win_idx) == N_REQ - 1)
            ptr_d = '0;
          else
            ptr_d = PW'(int'(win_idx) + 1);
`endif
        end
      end
      WAIT: begin
        if (mem_done) begin
          done_d = bus.gnt;
          if (!we) rdat_d = bus.mi_rd_data;
        end
      end
      DONE:    gnt_d = '0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Expected grant order follows MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // memory model
  bit         auto_en = 1'b0;
  int         lat = 1;
  logic [7:0] rd_val = 8'h00;
  logic       m_wr = 1'b0, m_rd = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       t_wr = 1'b0, t_rd = 1'b0;
  logic [7:0] t_data = 8'h00;
  logic       mem_w;

  assign bus.mi_wr_done = m_wr | t_wr;
  assign bus.mi_rd_done = m_rd | t_rd;
  assign bus.mi_rd_data = t_rd ? t_data : m_data;

  always begin
    @(negedge clk);
    if (auto_en && nreset &&
        (bus.mi_rd_start || bus.mi_wr_start)) begin
      mem_w = bus.mi_wr_start;
      repeat (lat) @(posedge clk);
      #1;
      if (mem_w) m_wr = 1'b1;
      else begin
        m_rd   = 1'b1;
        m_data = rd_val;
      end
      @(posedge clk);
      #1;
      m_wr = 1'b0;
      m_rd = 1'b0;
    end
  end

  // monitor
  int         cyc = 0;
  int         n_rd_st = 0, n_wr_st = 0, n_dones = 0;
  logic [2:0] iss_gnt[$];
  int         iss_cyc[$];
  logic [7:0] st_addr = 8'h00, st_wdata = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (bus.mi_rd_start) n_rd_st++;
    if (bus.mi_wr_start) n_wr_st++;
    if (bus.mi_rd_start || bus.mi_wr_start) begin
      iss_gnt.push_back(bus.gnt);
      iss_cyc.push_back(cyc);
      st_addr  = bus.mi_addr;
      st_wdata = bus.mi_wr_data;
    end
    if (|bus.req_done) n_dones++;
  end

  task automatic set_req(input int i, input bit w,
                         input logic [7:0] a,
                         input logic [7:0] d);
    bus.req[i]          = 1'b1;
    bus.req_we[i]       = w;
    bus.req_addr[i*8 +: 8]  = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask

  // c = cycles from the req-sampling cycle through DONE, -1 on timeout
  task automatic wait_done(input int i, input int maxc,
                           output int c);
    c = 1;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (bus.req_done[i]) return;
      c++;
    end
    c = -1;
  endtask

  task automatic wait_start(input int s0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (n_rd_st + n_wr_st != s0) return;
    end
    $display("FAIL start_timeout got none want one");
    n_total++;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.gnt, bus.req_done, bus.mi_wr_start,
         bus.mi_rd_start} !== 8'h00)
      $display("FAIL reset_ctl got %h want 00",
               {bus.gnt, bus.req_done,
                bus.mi_wr_start, bus.mi_rd_start});
    else n_pass++;
    n_total++;
    if ({bus.mi_addr, bus.mi_wr_data, bus.rd_data} !== 24'h0)
      $display("FAIL reset_data got %h want 000000",
               {bus.mi_addr, bus.mi_wr_data, bus.rd_data});
    else n_pass++;
    @(posedge clk);
    #1 nreset = 1'b1;
  endtask

  task automatic test_single_read;
    int c, rs;
    auto_en = 1'b1;
    lat     = 4;
    rd_val  = 8'hA5;
    rs      = n_rd_st;
    @(posedge clk);
    #1 set_req(1, 1'b0, 8'h3C, 8'h00);
    wait_done(1, 30, c);
    n_total++;
    if (c !== 7) $display("FAIL rd_latency got %0d want 7", c);
    else n_pass++;
    n_total++;
    if (n_rd_st !== rs + 1)
      $display("FAIL rd_starts got %0d want %0d", n_rd_st, rs + 1);
    else n_pass++;
    n_total++;
    if (st_addr !== 8'h3C)
      $display("FAIL rd_addr got %h want 3c", st_addr);
    else n_pass++;
    n_total++;
    if (bus.gnt !== 3'b010)
      $display("FAIL rd_gnt got %b want 010", bus.gnt);
    else n_pass++;
    @(posedge clk);
    #1 bus.req[1] = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.rd_data !== 8'hA5)
      $display("FAIL rd_data got %h want a5", bus.rd_data);
    else n_pass++;
    n_total++;
    if ({bus.gnt, bus.req_done} !== 6'b0)
      $display("FAIL rd_release got %b want 000000",
               {bus.gnt, bus.req_done});
    else n_pass++;
  endtask

  task automatic test_single_write;
    int c, rs, ws;
    lat = 2;
    rs  = n_rd_st;
    ws  = n_wr_st;
    @(posedge clk);
    #1 set_req(0, 1'b1, 8'h10, 8'h7E);
    wait_done(0, 30, c);
    n_total++;
    if (c !== 5) $display("FAIL wr_latency got %0d want 5", c);
    else n_pass++;
    n_total++;
    if ({n_wr_st, n_rd_st} !== {ws + 1, rs})
      $display("FAIL wr_starts got %0d/%0d want %0d/%0d",
               n_wr_st, n_rd_st, ws + 1, rs);
    else n_pass++;
    n_total++;
    if ({st_addr, st_wdata} !== 16'h107E)
      $display("FAIL wr_bus got %h want 107e",
               {st_addr, st_wdata});
    else n_pass++;
    n_total++;
    if (bus.rd_data !== 8'hA5)
      $display("FAIL wr_rd_hold got %h want a5", bus.rd_data);
    else n_pass++;
    @(posedge clk);
    #1 bus.req[0] = 1'b0;
  endtask

  task automatic test_stray_done;
    auto_en = 1'b0;
    @(posedge clk);
    #1 set_req(2, 1'b1, 8'h55, 8'h33);
    wait_start(n_rd_st + n_wr_st);
    @(posedge clk);
    #1;
    t_rd   = 1'b1;
    t_data = 8'hEE;
    @(posedge clk);
    #1 t_rd = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.req_done, bus.gnt} !== 6'b000100)
      $display("FAIL stray_ignored got %b want 000100",
               {bus.req_done, bus.gnt});
    else n_pass++;
    @(posedge clk);
    #1 t_wr = 1'b1;
    @(posedge clk);
    #1 t_wr = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.req_done !== 3'b100)
      $display("FAIL stray_wr_done got %b want 100",
               bus.req_done);
    else n_pass++;
    n_total++;
    if (bus.rd_data !== 8'hA5)
      $display("FAIL stray_rd_data got %h want a5", bus.rd_data);
    else n_pass++;
    @(posedge clk);
    #1 bus.req[2] = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    int c;
    auto_en = 1'b0;
    @(posedge clk);
    #1 set_req(1, 1'b0, 8'h44, 8'h00);
    wait_start(n_rd_st + n_wr_st);
    @(posedge clk);
    @(negedge clk);
    set_req(2, 1'b1, 8'h66, 8'h11);
    #2 nreset = 1'b0;
    #1;
    n_total++;
    if ({bus.gnt, bus.req_done, bus.mi_wr_start,
         bus.mi_rd_start} !== 8'h00)
      $display("FAIL rst_mid_ctl got %h want 00",
               {bus.gnt, bus.req_done,
                bus.mi_wr_start, bus.mi_rd_start});
    else n_pass++;
    n_total++;
    if ({bus.mi_addr, bus.rd_data} !== 16'h0)
      $display("FAIL rst_mid_data got %h want 0000",
               {bus.mi_addr, bus.rd_data});
    else n_pass++;
    @(posedge clk);
    #1;
    nreset  = 1'b1;
    auto_en = 1'b1;
    lat     = 1;
    wait_done(1, 30, c);
    n_total++;
    if (c < 0 || iss_gnt[$] !== 3'b010 || st_addr !== 8'h44)
      $display("FAIL rst_rearb got c=%0d g=%b a=%h want g=010 a=44",
               c, iss_gnt[$], st_addr);
    else n_pass++;
    @(posedge clk);
    #1 bus.req[1] = 1'b0;
    wait_done(2, 30, c);
    n_total++;
    if (c < 0 || {st_addr, st_wdata} !== 16'h6611)
      $display("FAIL rst_second got c=%0d bus=%h want 6611",
               c, {st_addr, st_wdata});
    else n_pass++;
    @(posedge clk);
    #1 bus.req[2] = 1'b0;
  endtask

  task automatic test_req_drop;
    int s0, d0;
    lat    = 3;
    rd_val = 8'h5A;
    s0     = n_rd_st + n_wr_st;
    d0     = n_dones;
    @(posedge clk);
    #1 set_req(2, 1'b0, 8'h77, 8'h00);
    wait_start(s0);
    @(posedge clk);
    #1 bus.req[2] = 1'b0;
    repeat (15) @(negedge clk);
    n_total++;
    if (n_dones !== d0 + 1)
      $display("FAIL drop_dones got %0d want %0d", n_dones, d0 + 1);
    else n_pass++;
    n_total++;
    if (n_rd_st + n_wr_st !== s0 + 1)
      $display("FAIL drop_starts got %0d want %0d",
               n_rd_st + n_wr_st, s0 + 1);
    else n_pass++;
    n_total++;
    if (bus.rd_data !== 8'h5A)
      $display("FAIL drop_rd_data got %h want 5a", bus.rd_data);
    else n_pass++;
  endtask

  task automatic test_contention;
    int n0;
    logic [2:0] exp_g[4];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    lat = 1;
    n0  = iss_gnt.size();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      set_req(i, 1'b0, 8'(i + 1), 8'h00);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (iss_gnt.size() >= n0 + 4) break;
    end
    @(posedge clk);
    #1 bus.req = '0;
    repeat (10) @(negedge clk);
    n_total++;
    if (iss_gnt.size() !== n0 + 4)
      $display("FAIL cont_count got %0d want %0d",
               iss_gnt.size() - n0, 4);
    else n_pass++;
    if (iss_gnt.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        n_total++;
        if (iss_gnt[n0 + i] !== exp_g[i])
          $display("FAIL cont_gnt%0d got %b want %b",
                   i, iss_gnt[n0 + i], exp_g[i]);
        else n_pass++;
      end
      for (int i = 1; i < 4; i++) begin
        n_total++;
        if (iss_cyc[n0 + i] - iss_cyc[n0 + i - 1] !== 4)
          $display("FAIL b2b_period%0d got %0d want 4", i,
                   iss_cyc[n0 + i] - iss_cyc[n0 + i - 1]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset;
    test_single_read;
    test_single_write;
    test_stray_done;
    test_reset_mid_wait;
    test_req_drop;
    test_contention;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
